// File: rtl/clock24_to12_tx_pkg.sv
// Shared definitions for the 12/24-hour time-propagation link:
// time-range limits and the transmit FSM state encoding.
package clock_pkg;

    localparam int HOURS_PER_HALF = 12;
    localparam int MAX_HOUR24     = 23;
    localparam int MAX_MINUTE     = 59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SEND    = 2'd2,
        HOLD    = 2'd3
    } tx_state_t;

endpackage

// File: rtl/clock24_to12_tx_if.sv
// Signal bundle between the 24-hour setter / 12-hour clock and the transmit block.
// master: the transmit block (drives out_*, busy, err_pulse).
// slave:  the surrounding system (drives the source request and gating inputs).
interface clock24_to12_tx_if;

    logic       setEnable;
    logic       src_propagate;
    logic [4:0] src_hours;
    logic [5:0] src_minutes;
    logic       loop_inhibit;

    logic       out_propagate;
    logic       out_isPM;
    logic [3:0] out_hours;
    logic [5:0] out_minutes;
    logic       busy;
    logic       err_pulse;

    modport master (
        input  setEnable, src_propagate, src_hours, src_minutes, loop_inhibit,
        output out_propagate, out_isPM, out_hours, out_minutes, busy, err_pulse
    );

    modport slave (
        output setEnable, src_propagate, src_hours, src_minutes, loop_inhibit,
        input  out_propagate, out_isPM, out_hours, out_minutes, busy, err_pulse
    );

endinterface

// File: rtl/clock24_to12_tx_hour24_to12.sv
// Combinational 24-hour to 12-hour hour conversion with range check.
// Shared with the display logic, so it carries no state of its own.
module hour24_to12
    import clock_pkg::*;
(
    input  logic [4:0] hours24,
    output logic       is_pm,
    output logic [3:0] hours12,
    output logic       valid
);

    // Map 0 -> 12 AM, 1..11 -> AM, 12 -> 12 PM, 13..23 -> h-12 PM; >23 is invalid.
    always_comb begin
        is_pm   = 1'b0;
        hours12 = 4'd12;
        valid   = 1'b0;
        if (hours24 <= 5'(MAX_HOUR24)) begin
            valid = 1'b1;
            is_pm = (hours24 >= 5'(HOURS_PER_HALF));
            if (hours24 == 5'd0 || hours24 == 5'(HOURS_PER_HALF)) begin
                hours12 = 4'd12;
            end else if (is_pm) begin
                hours12 = 4'(hours24 - 5'(HOURS_PER_HALF));
            end else begin
                hours12 = hours24[3:0];
            end
        end
    end

endmodule

// File: rtl/clock24_to12_tx.sv
// Transmit side of the 12/24-hour link: takes a committed 24-hour time,
// converts and validates it, emits one propagate pulse toward the 12-hour
// clock and then cools down. Requests arriving while busy are remembered
// (newest wins) and serviced after the cooldown.
module clock24_to12_tx
    import clock_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    clock24_to12_tx_if.master        link
);

    tx_state_t        state_reg, state_next;
    logic [4:0]       hours_lat_reg;
    logic [5:0]       minutes_lat_reg;
    logic             pending_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             out_is_pm_reg;
    logic [3:0]       out_hours_reg;
    logic [5:0]       out_minutes_reg;

    logic             req;
    logic             conv_is_pm;
    logic [3:0]       conv_hours;
    logic             hours_ok;
    logic             conv_ok;
    logic             cnt_done;

    // An echo from the 12-hour side must never bounce back, so loop_inhibit vetoes outright.
    assign req      = link.src_propagate & link.setEnable & ~link.loop_inhibit;
    assign conv_ok  = hours_ok & (minutes_lat_reg <= 6'(MAX_MINUTE));
    assign cnt_done = (cnt_reg == '0);

    hour24_to12 u_conv (
        .hours24 (hours_lat_reg),
        .is_pm   (conv_is_pm),
        .hours12 (conv_hours),
        .valid   (hours_ok)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a pending request (or one arriving right now) restarts conversion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req || pending_reg) state_next = CONVERT;
            CONVERT: state_next = conv_ok ? SEND : IDLE;
            SEND:    state_next = HOLD;
            HOLD: begin
                if (cnt_done) begin
                    state_next = (req || pending_reg) ? CONVERT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, pending flag, cooldown counter and the registered 12-hour outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hours_lat_reg   <= '0;
            minutes_lat_reg <= '0;
            pending_reg     <= 1'b0;
            cnt_reg         <= '0;
            out_is_pm_reg   <= 1'b0;
            out_hours_reg   <= 4'd12;
            out_minutes_reg <= '0;
        end else begin
            // Newest request always overwrites the latch, busy or not.
            if (req) begin
                hours_lat_reg   <= link.src_hours;
                minutes_lat_reg <= link.src_minutes;
            end

            // Entering CONVERT consumes whatever is latched, so the flag clears there.
            if (state_next == CONVERT) begin
                pending_reg <= 1'b0;
            end else if (req && state_reg != IDLE) begin
                pending_reg <= 1'b1;
            end

            if (state_reg == SEND) begin
                cnt_reg <= CNT_W'(HOLD_CYCLES - 1);
            end else if (state_reg == HOLD && !cnt_done) begin
                cnt_reg <= cnt_reg - 1'b1;
            end

            // Outputs change only on a successful conversion; rejected times leave them alone.
            if (state_reg == CONVERT && conv_ok) begin
                out_is_pm_reg   <= conv_is_pm;
                out_hours_reg   <= conv_hours;
                out_minutes_reg <= minutes_lat_reg;
            end
        end
    end

    // Pulses decode straight from state so an asynchronous reset kills them immediately.
    assign link.out_propagate = (state_reg == SEND);
    assign link.err_pulse     = (state_reg == CONVERT) && !conv_ok;
    assign link.busy          = (state_reg != IDLE);
    assign link.out_isPM      = out_is_pm_reg;
    assign link.out_hours     = out_hours_reg;
    assign link.out_minutes   = out_minutes_reg;

endmodule

// File: tb/tb_clock24_to12_tx.sv
// Self-checking bench for clock24_to12_tx: directed scenarios plus randomized
// requests, with a timing-window reference model feeding a scoreboard queue
// that a separate monitor drains.
module tb_clock24_to12_tx;

    localparam int HOLD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    clock24_to12_tx_if link();

    clock24_to12_tx #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .link  (link.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int at;
        bit pm;
        int h12;
        int m;
    } exp_t;

    exp_t exp_q[$];
    bit   busy_exp[int];

    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int err_cnt = 0;

    // Reference model state: requests are accepted fresh from idle_from onward.
    int idle_from;
    bit pend;
    int lat_h, lat_m;
    int last_h, last_pm, last_m;

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int to_12(input int h);
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        busy_exp.delete();
        pend = 0;
        idle_from = 0;
        lat_h = 0;
        lat_m = 0;
        last_h = 12;
        last_pm = 0;
        last_m = 0;
    endtask

    // Accepted request in cycle c: converted at c+1, pulse at c+2, cooldown of
    // HOLD cycles, and the last cooldown cycle can already accept the next one.
    task automatic model_cycle(input int c, input bit r, input int h, input int m);
        exp_t e;
        if (r) begin
            lat_h = h;
            lat_m = m;
        end
        if (c >= idle_from && (r || pend)) begin
            pend = 0;
            if (lat_h <= 23 && lat_m <= 59) begin
                e = '{is_err: 1'b0, at: c + 2, pm: (lat_h >= 12), h12: to_12(lat_h), m: lat_m};
                idle_from = c + HOLD + 2;
            end else begin
                e = '{is_err: 1'b1, at: c + 1, pm: 1'b0, h12: 0, m: 0};
                idle_from = c + 2;
            end
            exp_q.push_back(e);
            for (int k = c + 1; k <= idle_from; k++) begin
                if (!(e.is_err && k == idle_from)) busy_exp[k] = 1'b1;
            end
        end else if (r) begin
            pend = 1;
        end
    endtask

    task automatic drive(input bit p, input bit en, input bit inh, input int h, input int m);
        @(negedge clk);
        link.src_propagate = p;
        link.setEnable     = en;
        link.loop_inhibit  = inh;
        link.src_hours     = 5'(h);
        link.src_minutes   = 6'(m);
        if (reset) model_cycle(cyc, p && en && !inh, h & 31, m & 63);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic request(input int h, input int m);
        drive(1'b1, 1'b1, 1'b0, h, m);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_propagate"}, int'(link.out_propagate), 0);
        check_eq({tag, "_hours"},     int'(link.out_hours), 12);
        check_eq({tag, "_isPM"},      int'(link.out_isPM), 0);
        check_eq({tag, "_minutes"},   int'(link.out_minutes), 0);
        check_eq({tag, "_busy"},      int'(link.busy), 0);
        check_eq({tag, "_err"},       int'(link.err_pulse), 0);
    endtask

    // Monitor: pops the scoreboard whenever an event is due or the DUT shows one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (link.out_propagate) pulse_cnt++;
                if (link.err_pulse) err_cnt++;
                while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                    e = exp_q.pop_front();
                    check_eq("missed_event_cycle", cyc, e.at);
                end
                if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                    e = exp_q.pop_front();
                    check_eq("event_kind", int'({link.out_propagate, link.err_pulse}), e.is_err ? 1 : 2);
                    if (!e.is_err) begin
                        check_eq("pulse_hours", int'(link.out_hours), e.h12);
                        check_eq("pulse_isPM", int'(link.out_isPM), int'(e.pm));
                        check_eq("pulse_minutes", int'(link.out_minutes), e.m);
                        last_h = e.h12;
                        last_pm = int'(e.pm);
                        last_m = e.m;
                    end else begin
                        check_eq("err_hold_hours", int'(link.out_hours), last_h);
                        check_eq("err_hold_isPM", int'(link.out_isPM), last_pm);
                        check_eq("err_hold_minutes", int'(link.out_minutes), last_m);
                    end
                end else if (link.out_propagate || link.err_pulse) begin
                    check_eq("unexpected_event", int'({link.out_propagate, link.err_pulse}), 0);
                end
                check_eq("busy", int'(link.busy), int'(busy_exp.exists(cyc)));
            end
        end
    end

    initial begin
        int p0, e0;
        bit en, inh;
        int h, m;

        link.src_propagate = 1'b0;
        link.setEnable     = 1'b0;
        link.loop_inhibit  = 1'b0;
        link.src_hours     = '0;
        link.src_minutes   = '0;
        model_reset();

        // 1: reset release with no stimulus
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(6);
        check_reset_vals("t1");
        check_eq("t1_no_pulses", pulse_cnt + err_cnt, 0);

        // 2: basic conversions, explicit latency check on 13:30
        request(0, 0);   idle(10);
        request(12, 5);  idle(10);
        request(13, 30); idle(1);
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        check_eq("t2_latency_propagate", int'(link.out_propagate), 1);
        check_eq("t2_1330_hours", int'(link.out_hours), 1);
        check_eq("t2_1330_isPM", int'(link.out_isPM), 1);
        idle(10);
        request(23, 59); idle(10);

        // 3: out-of-range hours -> err at N+1, outputs keep 11:59 PM
        p0 = pulse_cnt;
        request(24, 10);
        idle(1);
        check_eq("t3_err_pulse", int'(link.err_pulse), 1);
        check_eq("t3_hours_kept", int'(link.out_hours), 11);
        check_eq("t3_minutes_kept", int'(link.out_minutes), 59);
        idle(8);
        check_eq("t3_no_propagate", pulse_cnt - p0, 0);

        // 4: requests during busy, newest wins
        p0 = pulse_cnt;
        request(9, 15);
        request(17, 40);
        idle(1);
        request(18, 0);
        idle(14);
        check_eq("t4_pulse_count", pulse_cnt - p0, 2);
        check_eq("t4_final_hours", int'(link.out_hours), 6);
        check_eq("t4_final_isPM", int'(link.out_isPM), 1);
        check_eq("t4_final_minutes", int'(link.out_minutes), 0);

        // 5: inhibited and disabled requests are ignored
        p0 = pulse_cnt;
        e0 = err_cnt;
        drive(1'b1, 1'b1, 1'b1, 3, 3); idle(8);
        drive(1'b1, 1'b0, 1'b0, 4, 4); idle(8);
        check_eq("t5_no_pulse", pulse_cnt - p0, 0);
        check_eq("t5_no_err", err_cnt - e0, 0);
        check_eq("t5_busy", int'(link.busy), 0);
        check_eq("t5_hours_kept", int'(link.out_hours), 6);

        // 6a: reset during SEND
        request(7, 7);
        idle(1);
        @(negedge clk);
        check_eq("t6_in_send", int'(link.out_propagate), 1);
        #1 reset = 1'b0;
        #1 model_reset();
        check_reset_vals("t6_send_rst");
        @(negedge clk);
        #1 reset = 1'b1;

        // 6b: reset during HOLD
        request(8, 8);
        idle(3);
        @(negedge clk);
        check_eq("t6_in_hold_busy", int'(link.busy), 1);
        check_eq("t6_in_hold_hours", int'(link.out_hours), 8);
        #1 reset = 1'b0;
        #1 model_reset();
        check_reset_vals("t6_hold_rst");
        @(negedge clk);
        #1 reset = 1'b1;
        p0 = pulse_cnt;
        request(20, 45);
        idle(10);
        check_eq("t6_after_rst_pulse", pulse_cnt - p0, 1);
        check_eq("t6_after_rst_hours", int'(link.out_hours), 8);
        check_eq("t6_after_rst_minutes", int'(link.out_minutes), 45);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 7)) begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
            end
            en  = ($urandom_range(0, 9) != 0);
            inh = ($urandom_range(0, 9) == 0);
            h   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
            m   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 59));
            drive(1'b1, en, inh, h, m);
        end
        idle(20);
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
